// File: rtl/nibble_deserializer_if.sv
// Bundles the serial input, control and buffered word output of the deserializer.
// The slave modport is the receiver's view; the master modport is the driver's view.
`timescale 1ns/1ps
interface nibble_deserializer_if #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 2
);
    localparam int BC_W = $clog2(DATA_W);
    localparam int FL_W = $clog2(FIFO_DEPTH + 1);

    logic              serial_in;
    logic              serial_en;
    logic              frame_sync;
    logic              out_ready;
    logic              clear_ovf;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [BC_W-1:0]   bit_cnt;
    logic [FL_W-1:0]   fill_level;
    logic              overflow;

    modport master (
        output serial_in, serial_en, frame_sync, out_ready, clear_ovf,
        input  data_out, out_valid, bit_cnt, fill_level, overflow
    );

    modport slave (
        input  serial_in, serial_en, frame_sync, out_ready, clear_ovf,
        output data_out, out_valid, bit_cnt, fill_level, overflow
    );
endinterface

// File: rtl/nibble_deserializer.sv
// Bit-serial receiver: gathers enabled bits LSB first into DATA_W-bit words and
// queues completed words in a small FIFO behind a valid/ready output.
//
// state  | meaning
// S_IDLE | no bits of the current word collected (bit_cnt = 0)
// S_SHIFT| partial word in progress, 1..DATA_W-1 bits collected
`timescale 1ns/1ps
module nibble_deserializer #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    nibble_deserializer_if.slave bus
);
    localparam int BC_W  = $clog2(DATA_W);
    localparam int FL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [FL_W-1:0]  FULL_CNT = FL_W'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t              state_q, state_d;
    logic [BC_W-1:0]     cnt_q, cnt_d;
    // New bits enter at the top and move down, so after DATA_W-1 bits the
    // first one sits at index 0 and the word is simply {last_bit, shift_q}.
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic                word_done;
    logic [DATA_W-1:0]   word;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [FL_W-1:0]     count;
    logic                ovf_q;
    logic                full, pop, push_ok, drop;

    // Collector state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Collector next state: frame_sync restarts the word, optionally with this cycle's bit as bit 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        word      = {bus.serial_in, shift_q};
        if (bus.frame_sync) begin
            if (bus.serial_en) begin
                state_d = S_SHIFT;
                cnt_d   = BC_W'(1);
                shift_d = (DATA_W-1)'({bus.serial_in, (DATA_W-1)'(0)} >> 1);
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
                shift_d = '0;
            end
        end else if (bus.serial_en) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SHIFT;
                    cnt_d   = BC_W'(1);
                    shift_d = (DATA_W-1)'({bus.serial_in, shift_q} >> 1);
                end
                S_SHIFT: begin
                    if (cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        shift_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = (DATA_W-1)'({bus.serial_in, shift_q} >> 1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            endcase
        end
    end

    assign full    = (count == FULL_CNT);
    assign pop     = bus.out_valid && bus.out_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push_ok = word_done && (!full || pop);
    assign drop    = word_done && full && !pop;

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push_ok && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push_ok) begin
            count <= count - 1'b1;
        end
    end

    // Sticky overflow; a fresh drop outranks clear_ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (bus.clear_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.out_valid  = (count != '0);
    assign bus.data_out   = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.bit_cnt    = cnt_q;
    assign bus.fill_level = count;
    assign bus.overflow   = ovf_q;

endmodule
